if_stage: RTL and testbench

//  Instruction-fetch stage: the producer side of the IF/ID interface consumed by ID_stage.
//  - Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
//  - Registers each fetched word, its PC and its decoded fields into the IF/ID register.
//  - Obeys the hazard-unit stall. Redirects on branch/JALR resolved in EXE.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/if_id_reg.sv | 57 +++++
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, bubble word, opcodes, IF/ID payload and field slices.
package riscv_pkg;

  localparam int unsigned PC_W    = 15;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC  = PC_W'(0);
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  // Fetch FSM: tracks whether imem_rdata carries a live response this cycle.
  typedef enum logic {
    F_EMPTY  = 1'b0,
    F_STREAM = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  function automatic logic [6:0] f_opcode(input logic [INSTR_W-1:0] i);
    return i[6:0];
  endfunction

  function automatic logic [4:0] f_rd(input logic [INSTR_W-1:0] i);
    return i[11:7];
  endfunction

  function automatic logic [2:0] f_funct3(input logic [INSTR_W-1:0] i);
    return i[14:12];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [INSTR_W-1:0] i);
    return i[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [INSTR_W-1:0] i);
    return i[24:20];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and bubble insert; decoded fields are registered alongside.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc_d,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               valid
);

  if_id_t nxt;

  // Bubble overrides the incoming word; the bubble's PC is zeroed.
  always_comb begin
    nxt.instr = instr_d;
    nxt.pc    = pc_d;
    nxt.valid = 1'b1;
    if (bubble) begin
      nxt.instr = NOP_INSTR;
      nxt.pc    = PC_W'(0);
      nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= NOP_INSTR;
      pc          <= PC_W'(0);
      valid       <= 1'b0;
      opcode      <= f_opcode(NOP_INSTR);
      funct3      <= f_funct3(NOP_INSTR);
      rd          <= f_rd(NOP_INSTR);
      rs1         <= f_rs1(NOP_INSTR);
      rs2         <= f_rs2(NOP_INSTR);
    end else if (!hold) begin
      instruction <= nxt.instr;
      pc          <= nxt.pc;
      valid       <= nxt.valid;
      opcode      <= f_opcode(nxt.instr);
      funct3      <= f_funct3(nxt.instr);
      rd          <= f_rd(nxt.instr);
      rs1         <= f_rs1(nxt.instr);
      rs2         <= f_rs2(nxt.instr);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request, response tracking and IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt performance counters.
module if_stage
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_HZRD,
  input  logic               branch_taken_EXE,
  input  logic [PC_W-1:0]    branch_address_EXE,
  input  logic               jalr_taken_EXE,
  input  logic [PC_W-1:0]    jalr_address_EXE,
  output logic [INSTR_W-1:0] instruction_IF_ID,
  output logic [PC_W-1:0]    pc_IF_ID,
  output logic [6:0]         OPCODE_IF_ID,
  output logic [2:0]         FUNCT3_IF_ID,
  output logic [4:0]         rd_IF_ID,
  output logic [4:0]         rs1_IF_ID,
  output logic [4:0]         rs2_IF_ID,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic               valid_IF_ID
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  f2_pc_q, f2_pc_d;
  logic [PC_W-1:0]  target;
  logic             redirect;
  logic             f2_valid;
  logic             ifid_hold;
  logic             ifid_bubble;

  assign redirect  = branch_taken_EXE | jalr_taken_EXE;
  assign target    = jalr_taken_EXE ? jalr_address_EXE : branch_address_EXE;
  assign f2_valid  = (state_q == F_STREAM);
  assign imem_addr = pc_q;
  assign imem_en   = ~stall_HZRD | redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= F_EMPTY;
      pc_q    <= RESET_PC;
      f2_pc_q <= PC_W'(0);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      f2_pc_q <= f2_pc_d;
    end
  end

  // Redirect beats stall; a stall alone freezes PC and the in-flight response.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    f2_pc_d = f2_pc_q;
    if (redirect) begin
      state_d = F_EMPTY;
      pc_d    = {target[PC_W-1:2], 2'b00};
    end else if (!stall_HZRD) begin
      state_d = F_STREAM;
      pc_d    = pc_q + PC_W'(4);
      f2_pc_d = pc_q;
    end
  end

  assign ifid_hold   = stall_HZRD & ~redirect;
  assign ifid_bubble = redirect | ~f2_valid;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .hold        (ifid_hold),
    .bubble      (ifid_bubble),
    .instr_d     (imem_rdata),
    .pc_d        (f2_pc_q),
    .instruction (instruction_IF_ID),
    .pc          (pc_IF_ID),
    .opcode      (OPCODE_IF_ID),
    .funct3      (FUNCT3_IF_ID),
    .rd          (rd_IF_ID),
    .rs1         (rs1_IF_ID),
    .rs2         (rs2_IF_ID),
    .valid       (valid_IF_ID)
  );

`ifdef IF_PERF_CNT_EN
  logic load_valid;
  logic load_bubble;

  assign load_valid  = ~redirect & ~stall_HZRD & f2_valid;
  assign load_bubble = redirect | (~stall_HZRD & ~f2_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (load_valid)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (load_bubble) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle synchronous instruction memory model.
module tb_if_stage;
  import riscv_pkg::*;

  logic               clk;
  logic               reset_n;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall_HZRD;
  logic               branch_taken_EXE;
  logic [PC_W-1:0]    branch_address_EXE;
  logic               jalr_taken_EXE;
  logic [PC_W-1:0]    jalr_address_EXE;
  logic [INSTR_W-1:0] instruction_IF_ID;
  logic [PC_W-1:0]    pc_IF_ID;
  logic [6:0]         OPCODE_IF_ID;
  logic [2:0]         FUNCT3_IF_ID;
  logic [4:0]         rd_IF_ID;
  logic [4:0]         rs1_IF_ID;
  logic [4:0]         rs2_IF_ID;
  logic               valid_IF_ID;
`ifdef IF_PERF_CNT_EN
  logic [31:0]        fetch_cnt;
  logic [31:0]        bubble_cnt;
`endif

  int vec  = 0;
  int errs = 0;

  logic [31:0] mem [0:8191];

  if_stage dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .imem_addr          (imem_addr),
    .imem_en            (imem_en),
    .imem_rdata         (imem_rdata),
    .stall_HZRD         (stall_HZRD),
    .branch_taken_EXE   (branch_taken_EXE),
    .branch_address_EXE (branch_address_EXE),
    .jalr_taken_EXE     (jalr_taken_EXE),
    .jalr_address_EXE   (jalr_address_EXE),
    .instruction_IF_ID  (instruction_IF_ID),
    .pc_IF_ID           (pc_IF_ID),
    .OPCODE_IF_ID       (OPCODE_IF_ID),
    .FUNCT3_IF_ID       (FUNCT3_IF_ID),
    .rd_IF_ID           (rd_IF_ID),
    .rs1_IF_ID          (rs1_IF_ID),
    .rs2_IF_ID          (rs2_IF_ID),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt          (fetch_cnt),
    .bubble_cnt         (bubble_cnt),
`endif
    .valid_IF_ID        (valid_IF_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr[14:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec++; if (valid_IF_ID !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", valid_IF_ID); end
    vec++; if (instruction_IF_ID !== 32'h00000013) begin errs++; $display("FAIL rst_instr got %h exp 00000013", instruction_IF_ID); end
    vec++; if (pc_IF_ID !== 15'h0) begin errs++; $display("FAIL rst_pc got %h exp 0", pc_IF_ID); end
    vec++; if (imem_addr !== 15'h0) begin errs++; $display("FAIL rst_imem_addr got %h exp 0", imem_addr); end
    vec++; if ({OPCODE_IF_ID, FUNCT3_IF_ID, rd_IF_ID, rs1_IF_ID, rs2_IF_ID} !== {7'h13, 3'd0, 5'd0, 5'd0, 5'd0})
      begin errs++; $display("FAIL rst_fields got %h/%h/%h/%h/%h exp 13/0/0/0/0", OPCODE_IF_ID, FUNCT3_IF_ID, rd_IF_ID, rs1_IF_ID, rs2_IF_ID); end
`ifdef IF_PERF_CNT_EN
    vec++; if ({fetch_cnt, bubble_cnt} !== 64'd0) begin errs++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", fetch_cnt, bubble_cnt); end
`endif
  endtask

  task automatic test_fetch();
    vec++; if (imem_addr !== 15'h0) begin errs++; $display("FAIL t1_addr0 got %h exp 0", imem_addr); end
    vec++; if (imem_en !== 1'b1) begin errs++; $display("FAIL t1_en got %b exp 1", imem_en); end
    tick();
    vec++; if (imem_addr !== 15'h4) begin errs++; $display("FAIL t1_addr4 got %h exp 4", imem_addr); end
    vec++; if (valid_IF_ID !== 1'b0) begin errs++; $display("FAIL t1_first_bubble got %b exp 0", valid_IF_ID); end
    tick();
    vec++; if (imem_addr !== 15'h8) begin errs++; $display("FAIL t1_addr8 got %h exp 8", imem_addr); end
    vec++; if (instruction_IF_ID !== 32'h00d30293) begin errs++; $display("FAIL t1_instr got %h exp 00d30293", instruction_IF_ID); end
    vec++; if ({OPCODE_IF_ID, rd_IF_ID, rs1_IF_ID, FUNCT3_IF_ID} !== {7'h13, 5'd5, 5'd6, 3'd0})
      begin errs++; $display("FAIL t1_fields got op %h rd %0d rs1 %0d f3 %0d exp 13/5/6/0", OPCODE_IF_ID, rd_IF_ID, rs1_IF_ID, FUNCT3_IF_ID); end
    vec++; if ({pc_IF_ID, valid_IF_ID} !== {15'h0, 1'b1}) begin errs++; $display("FAIL t1_pcv got %h/%b exp 0/1", pc_IF_ID, valid_IF_ID); end
  endtask

  task automatic test_decode();
    tick();
    vec++; if (instruction_IF_ID !== 32'hf853ae23) begin errs++; $display("FAIL t2_instr got %h exp f853ae23", instruction_IF_ID); end
    vec++; if ({OPCODE_IF_ID, FUNCT3_IF_ID, rs1_IF_ID, rs2_IF_ID, rd_IF_ID} !== {7'h23, 3'd2, 5'd7, 5'd5, 5'd28})
      begin errs++; $display("FAIL t2_fields got %h/%0d/%0d/%0d/%0d exp 23/2/7/5/28", OPCODE_IF_ID, FUNCT3_IF_ID, rs1_IF_ID, rs2_IF_ID, rd_IF_ID); end
    vec++; if (pc_IF_ID !== 15'h4) begin errs++; $display("FAIL t2_pc got %h exp 4", pc_IF_ID); end
  endtask

  task automatic test_stall();
    tick();
    vec++; if ({pc_IF_ID, instruction_IF_ID} !== {15'h8, 32'hA0000002}) begin errs++; $display("FAIL t3_pre got %h/%h exp 8/a0000002", pc_IF_ID, instruction_IF_ID); end
    stall_HZRD = 1'b1;
    #1;
    vec++; if (imem_en !== 1'b0) begin errs++; $display("FAIL t3_en got %b exp 0", imem_en); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if ({pc_IF_ID, instruction_IF_ID, valid_IF_ID, imem_addr} !== {15'h8, 32'hA0000002, 1'b1, 15'h10})
        begin errs++; $display("FAIL t3_hold%0d got pc %h ins %h v %b addr %h", i, pc_IF_ID, instruction_IF_ID, valid_IF_ID, imem_addr); end
    end
    stall_HZRD = 1'b0;
    tick();
    vec++; if ({pc_IF_ID, instruction_IF_ID} !== {15'hC, 32'hA0000003}) begin errs++; $display("FAIL t3_pc12 got %h/%h exp c/a0000003", pc_IF_ID, instruction_IF_ID); end
    tick();
    vec++; if ({pc_IF_ID, instruction_IF_ID} !== {15'h10, 32'hA0000004}) begin errs++; $display("FAIL t3_pc16 got %h/%h exp 10/a0000004", pc_IF_ID, instruction_IF_ID); end
  endtask

  task automatic run_redirect(input logic br, input logic [14:0] br_a, input logic jr,
                              input logic [14:0] jr_a, input logic [14:0] exp_pc, input logic [31:0] exp_ins);
    branch_taken_EXE = br; branch_address_EXE = br_a;
    jalr_taken_EXE = jr;   jalr_address_EXE = jr_a;
    tick();
    branch_taken_EXE = 1'b0; jalr_taken_EXE = 1'b0;
    vec++; if (imem_addr !== exp_pc) begin errs++; $display("FAIL t4_target got %h exp %h", imem_addr, exp_pc); end
    for (int i = 0; i < 2; i++) begin
      vec++; if ({valid_IF_ID, instruction_IF_ID, OPCODE_IF_ID} !== {1'b0, 32'h00000013, 7'h13})
        begin errs++; $display("FAIL t4_bubble%0d got v %b ins %h", i, valid_IF_ID, instruction_IF_ID); end
      tick();
    end
    vec++; if ({valid_IF_ID, pc_IF_ID, instruction_IF_ID} !== {1'b1, exp_pc, exp_ins})
      begin errs++; $display("FAIL t4_land got v %b pc %h ins %h exp pc %h ins %h", valid_IF_ID, pc_IF_ID, instruction_IF_ID, exp_pc, exp_ins); end
  endtask

  task automatic test_branch();
    run_redirect(1'b1, 15'h0102, 1'b0, 15'h0000, 15'h0100, 32'hA0000040);
    run_redirect(1'b1, 15'h0200, 1'b1, 15'h0302, 15'h0300, 32'hA00000C0);
  endtask

  task automatic test_redirect_stall();
    stall_HZRD = 1'b1; branch_taken_EXE = 1'b1; branch_address_EXE = 15'h7FFF;
    #1;
    vec++; if (imem_en !== 1'b1) begin errs++; $display("FAIL t5_en got %b exp 1", imem_en); end
    tick();
    stall_HZRD = 1'b0; branch_taken_EXE = 1'b0;
    vec++; if ({imem_addr, valid_IF_ID} !== {15'h7FFC, 1'b0}) begin errs++; $display("FAIL t5_tgt got %h/%b exp 7ffc/0", imem_addr, valid_IF_ID); end
    tick();
    vec++; if ({imem_addr, valid_IF_ID} !== {15'h0000, 1'b0}) begin errs++; $display("FAIL t5_wrap got %h/%b exp 0/0", imem_addr, valid_IF_ID); end
    tick();
    vec++; if ({pc_IF_ID, instruction_IF_ID, valid_IF_ID} !== {15'h7FFC, 32'hA0001FFF, 1'b1})
      begin errs++; $display("FAIL t5_top got %h/%h/%b exp 7ffc/a0001fff/1", pc_IF_ID, instruction_IF_ID, valid_IF_ID); end
    tick();
    vec++; if ({pc_IF_ID, instruction_IF_ID} !== {15'h0000, 32'h00d30293}) begin errs++; $display("FAIL t5_zero got %h/%h exp 0/00d30293", pc_IF_ID, instruction_IF_ID); end
  endtask

  task automatic test_counters();
`ifdef IF_PERF_CNT_EN
    vec++; if (fetch_cnt !== 32'd9) begin errs++; $display("FAIL t6_fetch_cnt got %0d exp 9", fetch_cnt); end
    vec++; if (bubble_cnt !== 32'd7) begin errs++; $display("FAIL t6_bubble_cnt got %0d exp 7", bubble_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    #3;
    reset_n = 1'b0;
    #1;
    test_reset();
    #3;
    reset_n = 1'b1;
    tick();
    vec++; if ({valid_IF_ID, imem_addr} !== {1'b0, 15'h4}) begin errs++; $display("FAIL t6_rel1 got %b/%h exp 0/4", valid_IF_ID, imem_addr); end
    tick();
    vec++; if ({valid_IF_ID, pc_IF_ID, instruction_IF_ID} !== {1'b1, 15'h0, 32'h00d30293})
      begin errs++; $display("FAIL t6_rel2 got %b/%h/%h exp 1/0/00d30293", valid_IF_ID, pc_IF_ID, instruction_IF_ID); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'hA0000000 | 32'(i);
    mem[0] = 32'h00d30293;
    mem[1] = 32'hf853ae23;
    reset_n = 1'b0;
    stall_HZRD = 1'b0;
    branch_taken_EXE = 1'b0; branch_address_EXE = 15'h0;
    jalr_taken_EXE = 1'b0;   jalr_address_EXE = 15'h0;
    #12;
    test_reset();
    #10;
    reset_n = 1'b1;
    test_fetch();
    test_decode();
    test_stall();
    test_branch();
    test_redirect_stall();
    test_counters();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
